wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Owns the single write port (we3/a3/wd3) of the 32x32 register file and merges two writeback producers.
  - The in-order pipeline writeback: fixed priority, never back-pressured.
  - A long-latency unit (mul/div, load miss): valid/ready handshake into a small FIFO.
- Exports a pending-write vector so the hazard unit can stall readers and WAW conflicts.
- Exports a starvation stall so queued long-unit results always drain.

Parameters:
- DEPTH, 4, long-unit FIFO entries (power of two, >=2).
- MAX_STARVE, 8, consecutive cycles a non-empty FIFO may be blocked by pipeline writes before stall_pipe asserts.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pipe_we  in  1  pipeline writeback request.
- pipe_a  in  5  pipeline destination register.
- pipe_wd  in  32  pipeline write data.
- lu_valid  in  1  long-unit result valid.
- lu_ready  out  1  FIFO can accept (= !full).
- lu_a  in  5  long-unit destination register.
- lu_wd  in  32  long-unit write data.
- we3  out  1  register file write enable.
- a3  out  5  register file write address.
- wd3  out  32  register file write data.
- pend  out  32  bit r = a valid FIFO entry targets register r.
- stall_pipe  out  1  request the pipeline to hold writeback for one cycle.

Behaviour:
- Reset (async): FIFO empty, pointers 0, starve_cnt 0. While reset is high: we3=0, lu_ready=0, pend=0, stall_pipe=0. a3/wd3 are don't-care but driven 0.
- lu handshake:
  - Enqueue when lu_valid && lu_ready.
  - lu_ready = !full and does not depend on same-cycle dequeue (no full-bypass).
  - lu_a==0 is accepted (handshake completes) but not enqueued; the write is dropped.
  - lu_a/lu_wd must stay stable while lu_valid && !lu_ready.
- Port select, combinational, same cycle, no added latency:
  - pipe_we && pipe_a!=0: we3=1, a3=pipe_a, wd3=pipe_wd. FIFO holds.
  - Otherwise, if FIFO is non-empty: we3=1, a3/wd3 = head entry, and the head pops on this clock edge.
  - Otherwise: we3=0, a3=0, wd3=0.
  - pipe_we with pipe_a==0 is treated as no pipeline write, so the FIFO may drain that cycle. Writes to x0 never reach we3.
- Simultaneous enqueue and dequeue are allowed in the same cycle. Count is unchanged; pointers wrap modulo DEPTH.
- pend: OR over valid entries of one-hot(addr). Combinational from current state. Excludes an entry being enqueued this cycle; includes the head until the edge it pops.
- Starvation:
  - starve_cnt increments (saturating at MAX_STARVE) each cycle the FIFO is non-empty and a pipeline write wins.
  - It clears to 0 on any dequeue or when the FIFO is empty.
  - stall_pipe = (starve_cnt==MAX_STARVE) && !empty.
  - Contract: when stall_pipe=1 the pipeline presents pipe_we=0, so the head drains next.
  - If the pipeline violates this, the pipeline still wins and the counter holds.
- Ordering: no reordering within the FIFO.
  - Hazard unit contract: no pipeline instruction may write a register whose pend bit is set (WAW).
  - The bench asserts this contract as a property.

Decomposition:
- Shared package cpu_pkg:
  - REG_AW=5, XLEN=32, NREGS=32.
  - Typedef wb_req_t {logic [4:0] a; logic [31:0] wd;}.
- Natural sub-module wb_fifo: synchronous FIFO of wb_req_t with push/pop/full/empty, per-entry valid bits, and an exported entry array for the pend computation.
- The top level holds the select mux and starve counter.

Test Plan:
- Reset mid-operation: enqueue 3 entries, assert reset asynchronously between edges -> we3=0, pend=0, lu_ready=0 immediately; after release the FIFO is empty and lu_ready=1.
- Pipe only: pipe_we=1, pipe_a=5, pipe_wd=0xDEADBEEF -> same cycle we3=1, a3=5, wd3=0xDEADBEEF; pipe_a=0 -> we3=0.
- LU drain: idle pipe, push (a=7, 0x11) then (a=9, 0x22) -> pend has bits 7 and 9; writes appear in order on consecutive cycles; pend returns to 0.
- Full: push DEPTH entries with the pipe busy -> lu_ready=0 after the 4th; lu_valid held 3 cycles is not accepted; the first idle pipe cycle pops and lu_ready=1 next cycle.
- Starvation: 1 entry queued, pipe_we=1 every cycle -> stall_pipe=1 on the 9th cycle (MAX_STARVE=8); drop pipe_we -> entry written, stall_pipe=0, counter 0.
- x0 and wrap: lu push a=0 -> handshake completes, no pend bit, no we3; push and pop concurrently for 10 cycles -> pointers wrap, data order preserved, matching a scoreboard model.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and sizes used by the writeback path.
package cpu_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] a;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NREGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; exposes every slot and its valid bit so the
// owner can build a pending-register vector.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_req_t               push_data,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic    [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic    [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic    [PW:0]      count_q, count_d;
  logic    [DEPTH-1:0] valid_q, valid_d;
  wb_req_t [DEPTH-1:0] mem_q;
  logic                do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // No full-bypass: a push against a full FIFO is refused even if the head pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign entries = mem_q;
  assign valid   = valid_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-unit results queue
// in a FIFO and drain on idle cycles, with a starvation stall to force draining.
module wb_write_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_STARVE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_a,
  input  logic [XLEN-1:0]   pipe_wd,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_a,
  input  logic [XLEN-1:0]   lu_wd,
  output logic              we3,
  output logic [REG_AW-1:0] a3,
  output logic [XLEN-1:0]   wd3,
  output logic [NREGS-1:0]  pend,
  output logic              stall_pipe
);

  localparam int unsigned SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  wb_req_t             push_req, head;
  wb_req_t [DEPTH-1:0] fifo_entries;
  logic    [DEPTH-1:0] fifo_valid;
  logic                full, empty, push, pop, pipe_win;
  logic    [SW-1:0]    starve_q, starve_d;

  // A pipeline write to x0 is no write at all, so it must not block the FIFO.
  assign pipe_win = pipe_we && (pipe_a != '0);
  assign lu_ready = !full && !reset;
  assign push     = lu_valid && lu_ready && (lu_a != '0);
  assign pop      = !pipe_win && !empty && !reset;
  assign push_req = '{a: lu_a, wd: lu_wd};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .entries   (fifo_entries),
    .valid     (fifo_valid)
  );

  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (!reset) begin
      if (pipe_win) begin
        we3 = 1'b1;
        a3  = pipe_a;
        wd3 = pipe_wd;
      end else if (!empty) begin
        we3 = 1'b1;
        a3  = head.a;
        wd3 = head.wd;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (fifo_valid[i]) begin
        pend = pend | reg_onehot(fifo_entries[i].a);
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (pipe_win && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign stall_pipe = (starve_q == STARVE_MAX) && !empty;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: vector table, hand sequences, and a per-cycle
// scoreboard model of the FIFO, pend vector and starvation counter.
module tb_wb_write_arbiter;
  import cpu_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned MAX_STARVE = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_we;
  logic [REG_AW-1:0] pipe_a;
  logic [XLEN-1:0]   pipe_wd;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_a;
  logic [XLEN-1:0]   lu_wd;
  logic              we3;
  logic [REG_AW-1:0] a3;
  logic [XLEN-1:0]   wd3;
  logic [NREGS-1:0]  pend;
  logic              stall_pipe;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .DEPTH      (DEPTH),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_we    (pipe_we),
    .pipe_a     (pipe_a),
    .pipe_wd    (pipe_wd),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_a       (lu_a),
    .lu_wd      (lu_wd),
    .we3        (we3),
    .a3         (a3),
    .wd3        (wd3),
    .pend       (pend),
    .stall_pipe (stall_pipe)
  );

  typedef struct {
    logic              pwe;
    logic [REG_AW-1:0] pa;
    logic [XLEN-1:0]   pwd;
    logic              ewe;
    logic [REG_AW-1:0] ea;
    logic [XLEN-1:0]   ewd;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  wb_req_t     sb_q[$];
  int unsigned m_starve = 0;
  vec_t        vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] p;
    p = '0;
    foreach (sb_q[i]) p[sb_q[i].a] = 1'b1;
    return p;
  endfunction

  // Called once per cycle at the falling edge: compare against the model, then advance it
  // to the state after the coming rising edge.
  task automatic monitor();
    logic        pw, mready, ew, es;
    logic [4:0]  ea;
    logic [31:0] ed, ep;
    int          sz;
    if (reset) begin
      sb_q.delete();
      m_starve = 0;
      return;
    end
    sz     = sb_q.size();
    pw     = pipe_we && (pipe_a != 5'd0);
    mready = (sz < int'(DEPTH));
    ep     = model_pend();
    es     = (m_starve == MAX_STARVE) && (sz > 0);
    ew = 1'b0; ea = '0; ed = '0;
    if (pw) begin
      ew = 1'b1; ea = pipe_a; ed = pipe_wd;
      chk("waw_contract", 32'(ep[pipe_a]), 32'd0);
    end else if (sz > 0) begin
      ew = 1'b1; ea = sb_q[0].a; ed = sb_q[0].wd;
    end
    chk("sb_we3", 32'(we3), 32'(ew));
    chk("sb_a3", 32'(a3), 32'(ea));
    chk("sb_wd3", wd3, ed);
    chk("sb_pend", pend, ep);
    chk("sb_lu_ready", 32'(lu_ready), 32'(mready));
    chk("sb_stall", 32'(stall_pipe), 32'(es));
    if (sz == 0 || !pw) m_starve = 0;
    else if (m_starve < MAX_STARVE) m_starve++;
    if (!pw && sz > 0) sb_q.delete(0);
    if (lu_valid && mready && lu_a != 5'd0) sb_q.push_back('{a: lu_a, wd: lu_wd});
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_a = '0; pipe_wd = '0;
    lu_valid = 1'b0; lu_a = '0; lu_wd = '0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < int'(2 * DEPTH + 4) && sb_q.size() > 0; i++) tick();
    #2;
    chk("drain_pend", pend, 32'd0);
    chk("drain_we3", 32'(we3), 32'd0);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd7,  32'h0000AAAA, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 5'd1,  32'h0,        1'b1, 5'd1,  32'h0};

    // Reset state, with requests presented that must be masked.
    idle();
    reset = 1'b1;
    pipe_we = 1'b1; pipe_a = 5'd5; pipe_wd = 32'h1;
    lu_valid = 1'b1; lu_a = 5'd6;
    #3;
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd0);
    chk("rst_pend", pend, 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    #1;
    chk("post_rst_lu_ready", 32'(lu_ready), 32'd1);
    tick();

    // Pipe-only combinational select.
    for (int i = 0; i < 5; i++) begin
      pipe_we = vecs[i].pwe; pipe_a = vecs[i].pa; pipe_wd = vecs[i].pwd;
      #2;
      chk("vec_we3", 32'(we3), 32'(vecs[i].ewe));
      chk("vec_a3", 32'(a3), 32'(vecs[i].ea));
      chk("vec_wd3", wd3, vecs[i].ewd);
      tick();
    end

    // LU drain: queue two entries behind the pipe, then let them out in order.
    pipe_we = 1'b1; pipe_a = 5'd3; pipe_wd = 32'h3;
    lu_valid = 1'b1; lu_a = 5'd7; lu_wd = 32'h11;
    #2;
    chk("lu_enq_pend_excl", pend, 32'd0);
    tick();
    lu_a = 5'd9; lu_wd = 32'h22;
    tick();
    idle();
    #2;
    chk("lu_pend_7_9", pend, (32'd1 << 7) | (32'd1 << 9));
    chk("lu_first_a3", 32'(a3), 32'd7);
    chk("lu_first_wd3", wd3, 32'h11);
    tick();
    #2;
    chk("lu_pend_9", pend, 32'd1 << 9);
    chk("lu_second_a3", 32'(a3), 32'd9);
    tick();
    #2;
    chk("lu_pend_clear", pend, 32'd0);
    chk("lu_idle_we3", 32'(we3), 32'd0);
    tick();

    // Full: fill under a busy pipe, then held lu_valid must be refused.
    pipe_we = 1'b1; pipe_a = 5'd3; pipe_wd = 32'h33;
    for (int i = 0; i < int'(DEPTH); i++) begin
      lu_valid = 1'b1; lu_a = 5'(10 + i); lu_wd = 32'h100 + 32'(i);
      #2;
      chk("fill_lu_ready", 32'(lu_ready), 32'd1);
      tick();
    end
    lu_a = 5'd14; lu_wd = 32'hE;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("full_lu_ready", 32'(lu_ready), 32'd0);
      tick();
    end
    pipe_we = 1'b0; pipe_a = '0;
    #2;
    chk("full_no_bypass", 32'(lu_ready), 32'd0);
    chk("full_pop_a3", 32'(a3), 32'd10);
    tick();
    #2;
    chk("full_ready_after_pop", 32'(lu_ready), 32'd1);
    tick();
    drain();

    // Starvation: one entry blocked by continuous pipeline writes.
    pipe_we = 1'b1; pipe_a = 5'd4; pipe_wd = 32'h44;
    lu_valid = 1'b1; lu_a = 5'd20; lu_wd = 32'hABCD;
    tick();
    lu_valid = 1'b0; lu_a = '0;
    for (int i = 1; i <= 9; i++) begin
      #2;
      chk("starve_stall", 32'(stall_pipe), 32'(i == 9));
      tick();
    end
    pipe_we = 1'b0; pipe_a = '0;
    #2;
    chk("starve_stall_held", 32'(stall_pipe), 32'd1);
    chk("starve_drain_a3", 32'(a3), 32'd20);
    chk("starve_drain_wd3", wd3, 32'hABCD);
    tick();
    #2;
    chk("starve_stall_clear", 32'(stall_pipe), 32'd0);
    tick();

    // x0 long-unit result: accepted but dropped.
    lu_valid = 1'b1; lu_a = 5'd0; lu_wd = 32'h55;
    #2;
    chk("x0_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    idle();
    #2;
    chk("x0_pend", pend, 32'd0);
    chk("x0_we3", 32'(we3), 32'd0);
    tick();

    // Concurrent push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      lu_valid = 1'b1; lu_a = 5'((i % 31) + 1); lu_wd = $urandom;
      tick();
    end
    drain();

    // Reset mid-operation, asserted between clock edges.
    pipe_we = 1'b1; pipe_a = 5'd3; pipe_wd = 32'h77;
    for (int i = 0; i < 3; i++) begin
      lu_valid = 1'b1; lu_a = 5'(21 + i); lu_wd = 32'h200 + 32'(i);
      tick();
    end
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_we3", 32'(we3), 32'd0);
    chk("midrst_pend", pend, 32'd0);
    chk("midrst_lu_ready", 32'(lu_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_rel_lu_ready", 32'(lu_ready), 32'd1);
    chk("midrst_rel_pend", pend, 32'd0);
    chk("midrst_rel_we3", 32'(we3), 32'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
